// File: rtl/demux1x2_buf_if.sv
// Handshake bundle for the 1-to-2 word demultiplexer: one input stream, two output channels.
// Latency: none (signal bundle only).
// Backpressure: in_ready flows back to the producer; YA_ready/YB_ready flow back from consumers.
interface demux1x2_buf_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] D;
  logic             S;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] YA;
  logic             YA_valid;
  logic             YA_ready;
  logic [WIDTH-1:0] YB;
  logic             YB_valid;
  logic             YB_ready;
  logic [7:0]       cnt_a;
  logic [7:0]       cnt_b;

  // Producer/consumer side: drives the input word and both output readies.
  modport master (
    output D, S, in_valid, YA_ready, YB_ready,
    input  in_ready, YA, YA_valid, YB, YB_valid, cnt_a, cnt_b
  );

  // Demultiplexer side.
  modport slave (
    input  D, S, in_valid, YA_ready, YB_ready,
    output in_ready, YA, YA_valid, YB, YB_valid, cnt_a, cnt_b
  );
endinterface

// File: rtl/demux1x2_buf.sv
// Small register-based FIFO whose head entry drives the channel output directly.
// Latency: a push into an empty FIFO is visible at the head one edge later.
// Backpressure: full is derived from the count alone, so a same-cycle pop never frees a slot early.
module demux1x2_buf_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head_dat,
  output logic             head_vld,
  output logic             full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             push_ok;
  logic             pop_ok;

  assign full     = (count == CW'(DEPTH));
  assign head_vld = (count != '0);
  assign push_ok  = push & ~full;
  assign pop_ok   = pop & head_vld;
  // An empty FIFO presents zero so the output is well defined after reset and after draining.
  assign head_dat = head_vld ? mem[rd_ptr] : '0;

  // Storage: write the incoming word at the tail slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push_ok) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  // Pointers: DEPTH is a power of two, so natural overflow gives the modulo wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
    end
  end

  // Occupancy: simultaneous push and pop leave the count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // A stalled head must stay put until it is taken.
  a_head_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (head_vld && !pop) |=> (head_vld && $stable(head_dat)));
endmodule

// Registered 1-to-2 demultiplexer: S steers each accepted word into channel A (0) or B (1).
// Latency: one cycle from accept to YX_valid when the target FIFO is empty; 1 word/cycle per channel.
// Backpressure: in_ready = !full of the selected FIFO only; a stalled consumer blocks only its own channel.
module demux1x2_buf #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input logic              clk,
  input logic              rst_n,
  demux1x2_buf_if.slave    bus
);
  logic             full_a;
  logic             full_b;
  logic             push_a;
  logic             push_b;
  logic             pop_a;
  logic             pop_b;
  logic [WIDTH-1:0] head_a;
  logic [WIDTH-1:0] head_b;
  logic             vld_a;
  logic             vld_b;
  logic [7:0]       cnt_a_q;
  logic [7:0]       cnt_b_q;

  // Ready depends only on S and FIFO fullness, never on the output readies.
  assign bus.in_ready = bus.S ? ~full_b : ~full_a;
  assign push_a       = bus.in_valid & bus.in_ready & ~bus.S;
  assign push_b       = bus.in_valid & bus.in_ready &  bus.S;
  assign pop_a        = vld_a & bus.YA_ready;
  assign pop_b        = vld_b & bus.YB_ready;

  assign bus.YA       = head_a;
  assign bus.YA_valid = vld_a;
  assign bus.YB       = head_b;
  assign bus.YB_valid = vld_b;
  assign bus.cnt_a    = cnt_a_q;
  assign bus.cnt_b    = cnt_b_q;

  demux1x2_buf_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push_a),
    .push_dat (bus.D),
    .pop      (bus.YA_ready),
    .head_dat (head_a),
    .head_vld (vld_a),
    .full     (full_a)
  );

  demux1x2_buf_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push_b),
    .push_dat (bus.D),
    .pop      (bus.YB_ready),
    .head_dat (head_b),
    .head_vld (vld_b),
    .full     (full_b)
  );

  // Delivery counters: one step per word handed to each consumer, wrapping at 256.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_a_q <= '0;
      cnt_b_q <= '0;
    end else begin
      if (pop_a) cnt_a_q <= cnt_a_q + 8'd1;
      if (pop_b) cnt_b_q <= cnt_b_q + 8'd1;
    end
  end
endmodule

// File: tb/tb_demux1x2_buf.sv
// Directed bench for the 1-to-2 demultiplexer with hand-computed expectations.
// Inputs change on the falling edge; outputs are checked shortly after.
// All comparisons funnel through one checking task that keeps the counts.
module tb_demux1x2_buf;
  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  demux1x2_buf_if #(.WIDTH(32)) bus ();

  demux1x2_buf #(.WIDTH(32), .DEPTH(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    errors       = 0;
    checks       = 0;
    rst_n        = 1'b0;
    bus.D        = '0;
    bus.S        = 1'b0;
    bus.in_valid = 1'b0;
    bus.YA_ready = 1'b0;
    bus.YB_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_ya_valid", 32'(bus.YA_valid), 32'd0);
    check("rst_yb_valid", 32'(bus.YB_valid), 32'd0);
    check("rst_ya",       bus.YA,            32'd0);
    check("rst_yb",       bus.YB,            32'd0);
    check("rst_cnt_a",    32'(bus.cnt_a),    32'd0);
    check("rst_cnt_b",    32'(bus.cnt_b),    32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: single word to A, consumer ready
    @(negedge clk);
    bus.D = 32'hDEADBEEF; bus.S = 1'b0; bus.in_valid = 1'b1; bus.YA_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    check("t1_ya",       bus.YA,            32'hDEADBEEF);
    check("t1_ya_valid", 32'(bus.YA_valid), 32'd1);
    check("t1_yb_valid", 32'(bus.YB_valid), 32'd0);
    @(negedge clk);
    #1;
    check("t1_cnt_a",    32'(bus.cnt_a),    32'd1);
    check("t1_ya_empty", 32'(bus.YA_valid), 32'd0);

    // 2: fill B while its consumer stalls
    bus.YA_ready = 1'b0; bus.YB_ready = 1'b0;
    @(negedge clk);
    bus.S = 1'b1; bus.D = 32'd1; bus.in_valid = 1'b1;
    #1 check("t2_rdy_w1", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    bus.D = 32'd2;
    #1 check("t2_rdy_w2", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    bus.D = 32'd3;
    #1 check("t2_rdy_w3", 32'(bus.in_ready), 32'd0);

    // 3: B full, A still accepts
    @(negedge clk);
    bus.S = 1'b0; bus.D = 32'hA5A5A5A5;
    #1 check("t3_rdy_a", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    check("t3_ya",       bus.YA,            32'hA5A5A5A5);
    check("t3_ya_valid", 32'(bus.YA_valid), 32'd1);
    check("t3_yb",       bus.YB,            32'd1);
    check("t3_yb_valid", 32'(bus.YB_valid), 32'd1);

    // 2 (cont.): drain B; word 3 only goes in once a slot was freed an edge earlier
    @(negedge clk);
    bus.S = 1'b1; bus.D = 32'd3; bus.in_valid = 1'b1; bus.YB_ready = 1'b1; bus.YA_ready = 1'b1;
    #1;
    check("t2_full_pop_rdy", 32'(bus.in_ready), 32'd0);
    check("t2_yb_w1",        bus.YB,            32'd1);
    @(negedge clk);
    #1;
    check("t2_yb_w2",    bus.YB,            32'd2);
    check("t2_rdy_free", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    check("t2_yb_w3",       bus.YB,            32'd3);
    check("t2_yb_w3_valid", 32'(bus.YB_valid), 32'd1);
    @(negedge clk);
    #1;
    check("t2_yb_empty", 32'(bus.YB_valid), 32'd0);
    check("t2_cnt_b",    32'(bus.cnt_b),    32'd3);
    check("t2_cnt_a",    32'(bus.cnt_a),    32'd2);

    // 4: alternating stream, both consumers ready, no bubbles
    do_reset();
    bus.YA_ready = 1'b1; bus.YB_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      bus.D = 32'(i); bus.S = i[0]; bus.in_valid = 1'b1;
      #1;
      check("t4_rdy", 32'(bus.in_ready), 32'd1);
      if (i > 0) begin
        if (((i - 1) % 2) == 0) begin
          check("t4_ya_valid", 32'(bus.YA_valid), 32'd1);
          check("t4_ya",       bus.YA,            32'(i - 1));
        end else begin
          check("t4_yb_valid", 32'(bus.YB_valid), 32'd1);
          check("t4_yb",       bus.YB,            32'(i - 1));
        end
      end
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    check("t4_yb_last", bus.YB, 32'd19);
    @(negedge clk);
    #1;
    check("t4_cnt_a", 32'(bus.cnt_a), 32'd10);
    check("t4_cnt_b", 32'(bus.cnt_b), 32'd10);

    // 5: asynchronous reset with words buffered in A
    bus.YA_ready = 1'b0;
    @(negedge clk);
    bus.S = 1'b0; bus.D = 32'hAA; bus.in_valid = 1'b1;
    @(negedge clk);
    bus.D = 32'hBB;
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1 check("t5_pre_valid", 32'(bus.YA_valid), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("t5_ya_valid", 32'(bus.YA_valid), 32'd0);
    check("t5_cnt_a",    32'(bus.cnt_a),    32'd0);
    check("t5_cnt_b",    32'(bus.cnt_b),    32'd0);
    @(negedge clk);
    rst_n = 1'b1; bus.YA_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1 check("t5_no_stale", 32'(bus.YA_valid), 32'd0);
    end
    @(negedge clk);
    bus.D = 32'h77; bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1 check("t5_first_after", bus.YA, 32'h77);

    // 6: counter wrap after 256 deliveries, then a held head
    do_reset();
    bus.YA_ready = 1'b1; bus.S = 1'b0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      bus.D = 32'(i); bus.in_valid = 1'b1;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    check("t6_cnt_255", 32'(bus.cnt_a), 32'd255);
    check("t6_ya_last", bus.YA,         32'd255);
    @(negedge clk);
    #1;
    check("t6_cnt_wrap", 32'(bus.cnt_a),    32'd0);
    check("t6_ya_empty", 32'(bus.YA_valid), 32'd0);

    bus.YA_ready = 1'b0;
    @(negedge clk);
    bus.D = 32'h12345678; bus.in_valid = 1'b1;
    @(negedge clk);
    bus.D = 32'h9;
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1 check("t6_full_rdy", 32'(bus.in_ready), 32'd0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1;
      check("t6_hold_ya",    bus.YA,            32'h12345678);
      check("t6_hold_valid", 32'(bus.YA_valid), 32'd1);
    end
    bus.YA_ready = 1'b1;
    @(negedge clk);
    #1 check("t6_ya_next", bus.YA, 32'h9);
    @(negedge clk);
    #1;
    check("t6_ya_done", 32'(bus.YA_valid), 32'd0);
    check("t6_cnt_end", 32'(bus.cnt_a),    32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
